uart_rx: RTL



---
 rtl/uart_rx.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver: synchronises the serial line, locates the start edge
// on the oversample tick, samples every bit at its midpoint and reports word or framing error.
module uart_rx #(
   parameter int OVERSAMPLING = 8,
   parameter int DATA_BITS    = 8
) (
   input  logic                 CLK,
   input  logic                 NRST,
   input  logic                 BAUDPULSE,
   input  logic                 RX_DSER,
   output logic [DATA_BITS-1:0] RX_DO,
   output logic                 RX_DRDY,
   output logic                 RX_BUSY,
   output logic                 RX_FERR
);

   localparam int TW = $clog2(OVERSAMPLING);
   localparam int BW = $clog2(DATA_BITS) + 1;

   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLING / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLING - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_e;

   logic [1:0]           sync_q;
   logic                 rx_s;

   state_e               state_q,  state_d;
   logic [TW-1:0]        tick_q,   tick_d;
   logic [BW-1:0]        bit_q,    bit_d;
   logic [DATA_BITS-1:0] shift_q,  shift_d;
   logic [DATA_BITS-1:0] data_q,   data_d;
   logic                 drdy_q,   drdy_d;
   logic                 ferr_q,   ferr_d;
   logic                 busy_q,   busy_d;

   assign rx_s = sync_q[1];

   // Two-flop synchroniser for the asynchronous line; idles high out of reset.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], RX_DSER};
      end
   end

   // Next-state logic: everything holds between oversample ticks.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      drdy_d  = 1'b0;
      ferr_d  = 1'b0;
      if (BAUDPULSE) begin
         case (state_q)
            ST_IDLE: begin
               if (!rx_s) begin
                  state_d = ST_START;
                  tick_d  = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_START: begin
               // Half a bit in: a high line here was only a glitch.
               if (tick_q == TICK_MID) begin
                  tick_d  = '0;
                  bit_d   = '0;
                  state_d = rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            ST_DATA: begin
               if (tick_q == TICK_LAST) begin
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  tick_d  = '0;
                  bit_d   = bit_q + BW'(1);
                  state_d = (bit_q == BIT_LAST) ? ST_STOP : ST_DATA;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            ST_STOP: begin
               if (tick_q == TICK_LAST) begin
                  tick_d  = '0;
                  state_d = ST_IDLE;
                  if (rx_s) begin
                     data_d = shift_q;
                     drdy_d = 1'b1;
                  end else begin
                     ferr_d = 1'b1;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               tick_d  = '0;
               bit_d   = '0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
      busy_d = (state_d != ST_IDLE);
   end

   // Receiver state and registered outputs.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         state_q <= ST_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         drdy_q  <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         drdy_q  <= drdy_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end

   assign RX_DO   = data_q;
   assign RX_DRDY = drdy_q;
   assign RX_FERR = ferr_q;
   assign RX_BUSY = busy_q;

endmodule
